// File: rtl/life_engine_pp.sv
// rtl/life_engine_pp.sv - ping-pong Game-of-Life engine with dual grid buffers
// Engine reads the displayed buffer, writes the back buffer, and swaps on done.
module life_engine_pp #(
  parameter int WORD_W        = 20,
  parameter int WORDS_PER_ROW = 64,
  parameter int ROWS          = 1024,
  parameter int ADDR_W        = $clog2(WORDS_PER_ROW*ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              run,
  input  logic              frame_tick,
  input  logic              wrap_mode,
  output logic              busy,
  output logic              done,
  output logic [15:0]       gen_count,
  output logic              disp_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data
);

  localparam int DEPTH  = WORDS_PER_ROW*ROWS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int SLOT_W = $clog2(WORDS_PER_ROW+2);
  localparam int COL_W  = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL} state_t;

  state_t r_state, w_next;

  logic [WORD_W-1:0] r_mem0 [DEPTH];
  logic [WORD_W-1:0] r_mem1 [DEPTH];
  logic [WORD_W-1:0] r_ram_q;
  logic [WORD_W-1:0] r_rd_data;

  logic [ROW_W-1:0]  r_row;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_ph;
  logic              r_wrap;
  logic              r_disp;
  logic [15:0]       r_gen;
  logic              r_done;

  // Read-return pipeline: what the word on r_ram_q belongs to.
  logic              r_q_vld;
  logic              r_q_zero;
  logic [1:0]        r_q_ph;
  logic              r_q_wr;
  logic [ROW_W-1:0]  r_q_row;
  logic [COL_W-1:0]  r_q_col;

  // Per line: next word, current word, MSB of the word before current.
  logic [WORD_W-1:0] r_t_nxt, r_t_cur, r_m_nxt, r_m_cur, r_b_nxt, r_b_cur;
  logic              r_t_msb, r_m_msb, r_b_msb;

  logic              w_trigger, w_last;
  logic              w_row_oor, w_col_oor, w_zero;
  logic [ROW_W-1:0]  w_row_idx;
  logic [COL_W-1:0]  w_col_idx;
  logic [ADDR_W-1:0] w_eng_addr, w_wr_addr;
  logic              w_eng_re, w_eng_we, w_host_we;
  logic [WORD_W-1:0] w_word, w_new;
  logic [WORD_W+1:0] w_tw, w_mw, w_bw;

  assign w_trigger = (r_state == S_IDLE) & ~r_done & (start | (run & frame_tick));
  assign w_last    = (r_row == ROW_W'(ROWS-1)) & (r_slot == SLOT_W'(WORDS_PER_ROW+1)) &
                     (r_ph == 2'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_TAIL;
      S_TAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Phase 0/1/2 reads the row above/at/below the current row.
  always_comb begin
    w_row_oor = 1'b0;
    w_row_idx = r_row;
    if (r_ph == 2'd0) begin
      if (r_row == '0) begin
        w_row_oor = 1'b1;
        w_row_idx = ROW_W'(ROWS-1);
      end else begin
        w_row_idx = r_row - ROW_W'(1);
      end
    end else if (r_ph == 2'd2) begin
      if (r_row == ROW_W'(ROWS-1)) begin
        w_row_oor = 1'b1;
        w_row_idx = '0;
      end else begin
        w_row_idx = r_row + ROW_W'(1);
      end
    end
    w_col_oor = 1'b0;
    w_col_idx = COL_W'(r_slot - SLOT_W'(1));
    if (r_slot == '0) begin
      w_col_oor = 1'b1;
      w_col_idx = COL_W'(WORDS_PER_ROW-1);
    end else if (r_slot == SLOT_W'(WORDS_PER_ROW+1)) begin
      w_col_oor = 1'b1;
      w_col_idx = '0;
    end
  end

  assign w_zero     = (w_row_oor | w_col_oor) & ~r_wrap;
  assign w_eng_addr = ADDR_W'(w_row_idx) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(w_col_idx);
  assign w_eng_re   = (r_state == S_RUN) & ~w_zero;
  assign w_host_we  = ld_we & (r_state == S_IDLE);

  assign w_word    = r_q_zero ? '0 : r_ram_q;
  assign w_tw      = {r_t_nxt[0], r_t_cur, r_t_msb};
  assign w_mw      = {r_m_nxt[0], r_m_cur, r_m_msb};
  // Bottom line is consumed the cycle its word returns, before it is shifted in.
  assign w_bw      = {w_word[0], r_b_nxt, r_b_cur[WORD_W-1]};
  assign w_eng_we  = r_q_vld & (r_q_ph == 2'd2) & r_q_wr;
  assign w_wr_addr = ADDR_W'(r_q_row) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(r_q_col);

  for (genvar i = 0; i < WORD_W; i++) begin : g_cell
    logic [3:0] w_n;
    assign w_n = 4'(w_tw[i]) + 4'(w_tw[i+1]) + 4'(w_tw[i+2]) +
                 4'(w_mw[i]) + 4'(w_mw[i+2]) +
                 4'(w_bw[i]) + 4'(w_bw[i+1]) + 4'(w_bw[i+2]);
    assign w_new[i] = (w_n == 4'd3) | (w_mw[i+1] & (w_n == 4'd2));
  end

  always_ff @(posedge clk) begin
    if (w_host_we) begin
      if (r_disp) r_mem1[ld_addr] <= ld_data;
      else        r_mem0[ld_addr] <= ld_data;
    end
    if (w_eng_we) begin
      if (r_disp) r_mem0[w_wr_addr] <= w_new;
      else        r_mem1[w_wr_addr] <= w_new;
    end
    if (w_eng_re) r_ram_q <= r_disp ? r_mem1[w_eng_addr] : r_mem0[w_eng_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row     <= '0;
      r_slot    <= '0;
      r_ph      <= '0;
      r_wrap    <= 1'b0;
      r_disp    <= 1'b0;
      r_gen     <= '0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
      r_q_vld   <= 1'b0;
      r_q_zero  <= 1'b0;
      r_q_ph    <= '0;
      r_q_wr    <= 1'b0;
      r_q_row   <= '0;
      r_q_col   <= '0;
      r_t_nxt   <= '0;
      r_t_cur   <= '0;
      r_t_msb   <= 1'b0;
      r_m_nxt   <= '0;
      r_m_cur   <= '0;
      r_m_msb   <= 1'b0;
      r_b_nxt   <= '0;
      r_b_cur   <= '0;
      r_b_msb   <= 1'b0;
    end else begin
      r_rd_data <= r_disp ? r_mem1[rd_addr] : r_mem0[rd_addr];
      r_done    <= (r_state == S_TAIL);
      if (r_state == S_TAIL) begin
        r_disp <= ~r_disp;
        r_gen  <= r_gen + 16'd1;
      end
      if (w_trigger) begin
        r_row  <= '0;
        r_slot <= '0;
        r_ph   <= '0;
        r_wrap <= wrap_mode;
      end else if (r_state == S_RUN) begin
        if (r_ph == 2'd2) begin
          r_ph <= '0;
          if (r_slot == SLOT_W'(WORDS_PER_ROW+1)) begin
            r_slot <= '0;
            r_row  <= r_row + ROW_W'(1);
          end else begin
            r_slot <= r_slot + SLOT_W'(1);
          end
        end else begin
          r_ph <= r_ph + 2'd1;
        end
      end
      r_q_vld  <= (r_state == S_RUN);
      r_q_zero <= w_zero;
      r_q_ph   <= r_ph;
      r_q_wr   <= (r_slot >= SLOT_W'(2));
      r_q_row  <= r_row;
      r_q_col  <= COL_W'(r_slot - SLOT_W'(2));
      if (r_q_vld) begin
        case (r_q_ph)
          2'd0: begin
            r_t_msb <= r_t_cur[WORD_W-1];
            r_t_cur <= r_t_nxt;
            r_t_nxt <= w_word;
          end
          2'd1: begin
            r_m_msb <= r_m_cur[WORD_W-1];
            r_m_cur <= r_m_nxt;
            r_m_nxt <= w_word;
          end
          default: begin
            r_b_msb <= r_b_cur[WORD_W-1];
            r_b_cur <= r_b_nxt;
            r_b_nxt <= w_word;
          end
        endcase
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign gen_count = r_gen;
  assign disp_sel  = r_disp;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_life_engine_pp.sv
// tb/tb_life_engine_pp.sv - scoreboard bench for life_engine_pp on a 32x8 grid
module tb_life_engine_pp;

  localparam int GEN_LEN = 146;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, run = 1'b0, frame_tick = 1'b0, wrap_mode = 1'b0;
  logic       busy, done, disp_sel;
  logic [15:0] gen_count;
  logic [4:0] rd_addr = '0, ld_addr = '0;
  logic [7:0] rd_data, ld_data = '0;
  logic       ld_we = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] g [8];
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  life_engine_pp #(.WORD_W(8), .WORDS_PER_ROW(4), .ROWS(8), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run), .frame_tick(frame_tick),
    .wrap_mode(wrap_mode), .busy(busy), .done(done), .gen_count(gen_count),
    .disp_sel(disp_sel), .rd_addr(rd_addr), .rd_data(rd_data), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < 8; r++) g[r] = '0;
  endtask

  task automatic set_cell(input int x, input int y);
    g[y][x] = 1'b1;
  endtask

  task automatic model_step(input bit wrap);
    logic [31:0] nx [8];
    int cnt, yy, xx;
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 32; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
              yy = r + dy;
              xx = x + dx;
              if (wrap) begin
                yy = (yy + 8) % 8;
                xx = (xx + 32) % 32;
                cnt += int'(g[yy][xx]);
              end else if (yy >= 0 && yy < 8 && xx >= 0 && xx < 32) begin
                cnt += int'(g[yy][xx]);
              end
            end
          end
        end
        nx[r][x] = (cnt == 3) || (g[r][x] && cnt == 2);
      end
    end
    for (int r = 0; r < 8; r++) g[r] = nx[r];
  endtask

  task automatic push_grid();
    for (int a = 0; a < 32; a++) exp_q.push_back(g[a/4][(a%4)*8 +: 8]);
  endtask

  task automatic load_grid();
    for (int a = 0; a < 32; a++) begin
      ld_we = 1'b1;
      ld_addr = 5'(a);
      ld_data = g[a/4][(a%4)*8 +: 8];
      tick();
    end
    ld_we = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [7:0] d);
    rd_addr = 5'(a);
    tick();
    d = rd_data;
  endtask

  // Advances the model, queues the expected grid, pulses start, waits for done.
  task automatic do_step(input bit wrap, output int lat);
    model_step(wrap);
    push_grid();
    wrap_mode = wrap;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || gen_count !== 16'd0 || disp_sel !== 1'b0 ||
        rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b gen=%0d disp=%b rd=%h, want all zero",
               busy, done, gen_count, disp_sel, rd_data);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_blinker();
    int lat;
    logic [7:0] d, e;
    clear_grid();
    for (int x = 9; x <= 11; x++) set_cell(x, 3);
    load_grid();
    do_step(1'b0, lat);
    n_tests++;
    if (lat !== GEN_LEN) begin
      n_fail++;
      $display("FAIL blinker_latency got %0d want %0d", lat, GEN_LEN);
    end
    n_tests++;
    if (gen_count !== 16'd1 || disp_sel !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL blinker_done_state gen=%0d disp=%b busy=%b want 1 1 0",
               gen_count, disp_sel, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width done=%b want 0", done);
    end
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL blinker_v addr %0d got %h want %h", a, d, e);
      end
    end
    read_word(9, d);
    n_tests++;
    if (d !== 8'h04) begin
      n_fail++;
      $display("FAIL blinker_v_word9 got %h want 04", d);
    end
    do_step(1'b0, lat);
    n_tests++;
    if (gen_count !== 16'd2 || disp_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL blinker_step2 gen=%0d disp=%b want 2 0", gen_count, disp_sel);
    end
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL blinker_h addr %0d got %h want %h", a, d, e);
      end
    end
  endtask

  task automatic test_seam();
    int lat;
    logic [7:0] d, e;
    clear_grid();
    for (int x = 7; x <= 9; x++) set_cell(x, 4);
    load_grid();
    do_step(1'b0, lat);
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL seam addr %0d got %h want %h", a, d, e);
      end
    end
    read_word(13, d);
    n_tests++;
    if (d !== 8'h01) begin
      n_fail++;
      $display("FAIL seam_word13 got %h want 01", d);
    end
  endtask

  task automatic test_edges();
    int lat;
    logic [7:0] d, e;
    for (int w = 1; w >= 0; w--) begin
      clear_grid();
      set_cell(30, 5); set_cell(31, 6);
      set_cell(29, 7); set_cell(30, 7); set_cell(31, 7);
      load_grid();
      for (int s = 0; s < 4; s++) begin
        do_step(1'(w), lat);
        for (int a = 0; a < 32; a++) begin
          read_word(a, d);
          e = exp_q.pop_front();
          n_tests++;
          if (d !== e) begin
            n_fail++;
            $display("FAIL edge_wrap%0d step%0d addr %0d got %h want %h", w, s, a, d, e);
          end
        end
      end
    end
  endtask

  task automatic test_handshake();
    int dones, done_at;
    logic [15:0] g0;
    logic [7:0] d, e;
    clear_grid();
    set_cell(3, 1); set_cell(4, 1); set_cell(5, 1); set_cell(4, 6); set_cell(5, 6);
    set_cell(6, 6); set_cell(20, 5); set_cell(21, 5); set_cell(20, 6); set_cell(21, 6);
    load_grid();
    model_step(1'b0);
    push_grid();
    wrap_mode = 1'b0;
    dones = 0;
    done_at = -1;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0 || c == 50);
      ld_we = (c == 60);
      ld_addr = 5'd29;
      ld_data = 8'hFF;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      tick();
    end
    start = 1'b0;
    ld_we = 1'b0;
    n_tests++;
    if (dones !== 1 || done_at !== GEN_LEN) begin
      n_fail++;
      $display("FAIL single_done dones=%0d at %0d want 1 at %0d", dones, done_at, GEN_LEN);
    end
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL busy_write addr %0d got %h want %h", a, d, e);
      end
    end
    g0 = gen_count;
    run = 1'b1;
    dones = 0;
    for (int c = 0; c < 650; c++) begin
      frame_tick = (c % 200 == 0) && (c < 600);
      if (frame_tick) begin
        model_step(1'b1);
        if (c == 400) push_grid();
      end
      wrap_mode = 1'b1;
      if (done) dones++;
      tick();
    end
    frame_tick = 1'b0;
    run = 1'b0;
    n_tests++;
    if (dones !== 3 || gen_count !== 16'(g0 + 16'd3)) begin
      n_fail++;
      $display("FAIL run_mode dones=%0d gen=%0d want 3 and %0d", dones, gen_count, g0 + 16'd3);
    end
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL run_grid addr %0d got %h want %h", a, d, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit bad;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_grid();
    for (int x = 9; x <= 11; x++) set_cell(x, 2);
    load_grid();
    read_word(9, d);
    n_tests++;
    if (d !== 8'h0E) begin
      n_fail++;
      $display("FAIL readback got %h want 0E", d);
    end
    wrap_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 1'b0;
    for (int c = 1; c < 70; c++) begin
      if (rd_data !== 8'h0E || busy !== 1'b1) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL busy_readback rd=%h busy=%b want 0E 1", rd_data, busy);
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || gen_count !== 16'd0 || disp_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b gen=%0d disp=%b want 0 0 0", busy, gen_count, disp_sel);
    end
    reset = 1'b0;
    tick();
    read_word(9, d);
    n_tests++;
    if (d !== 8'h0E) begin
      n_fail++;
      $display("FAIL reset_mid_pattern got %h want 0E", d);
    end
  endtask

  task automatic test_readback();
    int c;
    bit bad;
    logic [7:0] d, e;
    model_step(1'b0);
    push_grid();
    rd_addr = 5'd9;
    wrap_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    bad = 1'b0;
    while (!done && c < 400) begin
      if (rd_data !== 8'h0E) bad = 1'b1;
      tick();
      c++;
    end
    n_tests++;
    if (bad || c !== GEN_LEN || rd_data !== 8'h0E) begin
      n_fail++;
      $display("FAIL hold_until_done rd=%h at cycle %0d want 0E at %0d", rd_data, c, GEN_LEN);
    end
    tick();
    n_tests++;
    if (rd_data !== 8'h04) begin
      n_fail++;
      $display("FAIL after_swap rd=%h want 04", rd_data);
    end
    for (int a = 0; a < 32; a++) begin
      read_word(a, d);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL readback_grid addr %0d got %h want %h", a, d, e);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_blinker();
    test_seam();
    test_edges();
    test_handshake();
    test_reset_mid();
    test_readback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
